// File: rtl/capture_pkg.sv
// Shared types for the capture buffer: controller state encoding and channel-index width helper.
package capture_pkg;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    // Width of a channel index; a single-channel build still carries one bit.
    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/capture_buffer_if.sv
// Frame-in / word-out bundle for the capture buffer; input frames carry no backpressure,
// output words use valid/ready.
interface capture_buffer_if #(
    parameter int W        = 8,
    parameter int CHANNELS = 1
);
    import capture_pkg::*;

    localparam int CH_W = ch_w(CHANNELS);

    logic                   axiiv;
    logic [CHANNELS*W-1:0]  axiid;
    logic                   trigger;
    logic                   axiov;
    logic [W-1:0]           axiod;
    logic [CH_W-1:0]        axiochan;
    logic                   axiol;
    logic                   axioready;

    modport master (
        output axiiv, axiid, trigger, axioready,
        input  axiov, axiod, axiochan, axiol
    );

    modport slave (
        input  axiiv, axiid, trigger, axioready,
        output axiov, axiod, axiochan, axiol
    );

endinterface

// File: rtl/capture_frame_ram.sv
// Simple dual-port frame store: 1-cycle registered read, independent write port.
// No backpressure; the read port holds its last word while rd_en is low.
module capture_frame_ram #(
    parameter int DEPTH = 1024,
    parameter int DW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat_q <= mem_q[rd_addr];
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/capture_buffer.sv
// Trigger-gated ring capture with pre-trigger history, drained channel-by-channel; first word 2 cycles after DRAIN entry.
// Output is a registered word plus one-entry skid, so axioready never reaches the RAM read enable combinationally.
module capture_buffer
    import capture_pkg::*;
#(
    parameter int SAMPLE_DATA_WIDTH = 8,
    parameter int CHANNELS          = 1,
    parameter int DEPTH             = 1024,
    parameter int PRE_TRIGGER       = 256,
    parameter int HOLDOFF           = 1000
) (
    input  logic            clk,
    input  logic            rst,
    capture_buffer_if.slave bus,
    output state_t          state
);

    localparam int W    = SAMPLE_DATA_WIDTH;
    localparam int DW   = CHANNELS * W;
    localparam int AW   = $clog2(DEPTH);
    localparam int CH_W = ch_w(CHANNELS);
    localparam int FW   = $clog2(PRE_TRIGGER + 1);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int HW   = $clog2(HOLDOFF + 1);

    localparam logic [FW-1:0]   PRE_FILL = FW'(PRE_TRIGGER);
    localparam logic [AW-1:0]   PRE_PTR  = AW'(PRE_TRIGGER);
    localparam logic [CW-1:0]   POST_END = CW'(DEPTH - PRE_TRIGGER);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(CHANNELS - 1);
    localparam logic [HW-1:0]   HOLD_END = HW'(HOLDOFF - 1);

    state_t          state_q,    state_d;
    logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [FW-1:0]   fill_q,     fill_d;
    logic [CW-1:0]   post_q,     post_d;
    logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]   rd_cnt_q,   rd_cnt_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            frm_vld_q,  frm_vld_d;
    logic [CH_W-1:0] ch_idx_q,   ch_idx_d;
    logic            out_vld_q,  out_vld_d;
    logic [W-1:0]    out_dat_q,  out_dat_d;
    logic [CH_W-1:0] out_ch_q,   out_ch_d;
    logic            out_last_q, out_last_d;
    logic            skid_vld_q, skid_vld_d;
    logic [W-1:0]    skid_dat_q, skid_dat_d;
    logic [CH_W-1:0] skid_ch_q,  skid_ch_d;
    logic            skid_last_q, skid_last_d;

    logic          ram_we, ram_rd_en;
    logic [DW-1:0] ram_rd_dat;
    logic [W-1:0]  word_dat;
    logic          word_last, word_take, frame_done, stage_rdy, out_xfer;

    capture_frame_ram #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_dat  (bus.axiid),
        .rd_en   (ram_rd_en),
        .rd_addr (rd_ptr_q),
        .rd_dat  (ram_rd_dat)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        post_d      = post_q;
        rd_ptr_d    = rd_ptr_q;
        rd_cnt_d    = rd_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        frm_vld_d   = frm_vld_q;
        ch_idx_d    = ch_idx_q;
        out_vld_d   = out_vld_q;
        out_dat_d   = out_dat_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        skid_vld_d  = skid_vld_q;
        skid_dat_d  = skid_dat_q;
        skid_ch_d   = skid_ch_q;
        skid_last_d = skid_last_q;
        ram_we      = 1'b0;
        ram_rd_en   = 1'b0;
        stage_rdy   = !skid_vld_q;
        word_take   = frm_vld_q && stage_rdy;
        frame_done  = word_take && (ch_idx_q == LAST_CH);
        word_last   = (rd_cnt_q == DEPTH_C) && (ch_idx_q == LAST_CH);
        out_xfer    = out_vld_q && bus.axioready;
        word_dat    = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_idx_q == CH_W'(k)) word_dat = ram_rd_dat[k*W +: W];
        end

        case (state_q)
            ST_ARMED: begin
                ram_we = bus.axiiv;
                if (bus.axiiv) wr_ptr_d = wr_ptr_q + AW'(1);
                // fill is judged before this cycle's write, so a trigger one frame short is ignored
                if (bus.trigger && (fill_q == PRE_FILL)) begin
                    state_d  = ST_CAPTURE;
                    rd_ptr_d = wr_ptr_q - PRE_PTR;
                    rd_cnt_d = '0;
                    post_d   = bus.axiiv ? CW'(1) : '0;
                end else if (bus.axiiv && (fill_q != PRE_FILL)) begin
                    fill_d = fill_q + FW'(1);
                end
            end
            ST_CAPTURE: begin
                ram_we = bus.axiiv && (post_q != POST_END);
                if (ram_we) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    post_d   = post_q + CW'(1);
                end
                if (post_d == POST_END) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // next frame is fetched while the current frame's last channel leaves
                ram_rd_en = (rd_cnt_q != DEPTH_C) && (!frm_vld_q || frame_done);
                if (ram_rd_en) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    rd_cnt_d = rd_cnt_q + CW'(1);
                end
                if (out_xfer && out_last_q) begin
                    state_d    = ST_HOLDOFF;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLDOFF: begin
                hold_cnt_d = hold_cnt_q + HW'(1);
                if (hold_cnt_q == HOLD_END) begin
                    state_d = ST_ARMED;
                    fill_d  = '0;
                end
            end
            default: state_d = ST_ARMED;
        endcase

        if (ram_rd_en)       frm_vld_d = 1'b1;
        else if (frame_done) frm_vld_d = 1'b0;
        if (word_take)       ch_idx_d  = frame_done ? '0 : ch_idx_q + CH_W'(1);

        if (out_xfer || !out_vld_q) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_dat_d  = skid_dat_q;
                out_ch_d   = skid_ch_q;
                out_last_d = skid_last_q;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d  = word_take;
                out_last_d = word_take && word_last;
                if (word_take) begin
                    out_dat_d = word_dat;
                    out_ch_d  = ch_idx_q;
                end
            end
        end else if (word_take) begin
            skid_vld_d  = 1'b1;
            skid_dat_d  = word_dat;
            skid_ch_d   = ch_idx_q;
            skid_last_d = word_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARMED;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            post_q      <= '0;
            rd_ptr_q    <= '0;
            rd_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            frm_vld_q   <= 1'b0;
            ch_idx_q    <= '0;
            out_vld_q   <= 1'b0;
            out_dat_q   <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_dat_q  <= '0;
            skid_ch_q   <= '0;
            skid_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            post_q      <= post_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_cnt_q    <= rd_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            frm_vld_q   <= frm_vld_d;
            ch_idx_q    <= ch_idx_d;
            out_vld_q   <= out_vld_d;
            out_dat_q   <= out_dat_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
            skid_vld_q  <= skid_vld_d;
            skid_dat_q  <= skid_dat_d;
            skid_ch_q   <= skid_ch_d;
            skid_last_q <= skid_last_d;
        end
    end

    assign bus.axiov    = out_vld_q;
    assign bus.axiod    = out_dat_q;
    assign bus.axiochan = out_ch_q;
    assign bus.axiol    = out_last_q;
    assign state        = state_q;

endmodule

// File: tb/tb_capture_buffer.sv
// Directed bench for capture_buffer (2 channels, 16-frame record, 4 pre-trigger, holdoff 5);
// expected words are queued when a trigger is driven and popped as words transfer.
module tb_capture_buffer;
    import capture_pkg::*;

    typedef struct packed {
        logic [7:0] dat;
        logic       ch;
        logic       last;
    } exp_t;

    logic   clk;
    logic   rst;
    state_t dut_state;

    capture_buffer_if #(.W(8), .CHANNELS(2)) bus ();

    capture_buffer #(
        .SAMPLE_DATA_WIDTH (8),
        .CHANNELS          (2),
        .DEPTH             (16),
        .PRE_TRIGGER       (4),
        .HOLDOFF           (5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .state (dut_state)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pop = 0;
    int          frame_n = 0;
    bit          toggle_rdy = 1'b0;
    exp_t        sb[$];
    exp_t        e_mon;
    logic        prev_stall = 1'b0;
    logic [10:0] prev_word = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pops on every transfer, and stalled words must hold.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("stall_hold", 32'({bus.axiov, bus.axiod, bus.axiochan, bus.axiol}), 32'(prev_word));
            end
            if (bus.axiov && bus.axioready) begin
                n_cmp++;
                assert (sb.size() > 0) else begin
                    n_err++;
                    $error("FAIL unexpected_word: observed %0h with empty scoreboard expected no word", bus.axiod);
                end
                if (sb.size() > 0) begin
                    e_mon = sb.pop_front();
                    chk("word_dat",  32'(bus.axiod),    32'(e_mon.dat));
                    chk("word_chan", 32'(bus.axiochan), 32'(e_mon.ch));
                    chk("word_last", 32'(bus.axiol),    32'(e_mon.last));
                end
                n_pop++;
            end
        end
        prev_stall = !rst && bus.axiov && !bus.axioready;
        prev_word  = {bus.axiov, bus.axiod, bus.axiochan, bus.axiol};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit trig);
        bus.axiiv   = 1'b1;
        bus.axiid   = {8'(frame_n + 128), 8'(frame_n)};
        bus.trigger = trig;
        if (toggle_rdy) bus.axioready = ~bus.axioready;
        tick();
        frame_n++;
    endtask

    task automatic push_record(input int first);
        exp_t e;
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 2; c++) begin
                e.dat  = (c == 0) ? 8'(first + f) : 8'(first + f + 128);
                e.ch   = 1'(c);
                e.last = (f == 15) && (c == 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.axiiv     = 1'b0;
        bus.axiid     = '0;
        bus.trigger   = 1'b0;
        bus.axioready = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
        frame_n = 0;
        sb.delete();
    endtask

    task automatic wait_state(input state_t s, input bit trig, input int budget);
        int b = budget;
        while (dut_state != s && b > 0) begin
            send(trig);
            b--;
        end
        chk({"reach_", s.name()}, 32'(dut_state), 32'(s));
    endtask

    task automatic run_until_empty(input bit trig, input int budget);
        int b = budget;
        while (sb.size() != 0 && b > 0) begin
            send(trig);
            b--;
        end
        chk("drain_complete", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Checks d+2 first-word latency and a bubble-free 32-word record with ready held high.
    task automatic drain_nobubble(input string tag);
        wait_state(ST_DRAIN, 1'b0, 40);
        chk({tag, "_axiov_d0"}, 32'(bus.axiov), 32'd0);
        send(1'b0);
        chk({tag, "_axiov_d1"}, 32'(bus.axiov), 32'd0);
        send(1'b0);
        chk({tag, "_axiov_d2"}, 32'(bus.axiov), 32'd1);
        repeat (32) send(1'b0);
        chk({tag, "_words_left"}, 32'(sb.size()), 32'd0);
        chk({tag, "_state_end"}, 32'(dut_state), 32'(ST_HOLDOFF));
        sb.delete();
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_axiov",    32'(bus.axiov),    32'd0);
        chk("rst_axiod",    32'(bus.axiod),    32'd0);
        chk("rst_axiochan", 32'(bus.axiochan), 32'd0);
        chk("rst_axiol",    32'(bus.axiol),    32'd0);
        chk("rst_state",    32'(dut_state),    32'(ST_ARMED));

        // Basic record: trigger with frame 10 -> frames 6..21
        repeat (10) send(1'b0);
        push_record(6);
        send(1'b1);
        chk("t1_accept_state", 32'(dut_state), 32'(ST_CAPTURE));
        drain_nobubble("t1");

        // Early triggers ignored until 4 frames are held; one-short trigger ignored
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(1'b1);
            chk("t2_early_trig_ignored", 32'(dut_state), 32'(ST_ARMED));
        end
        send(1'b0);
        chk("t2_still_armed", 32'(dut_state), 32'(ST_ARMED));
        push_record(1);
        send(1'b1);
        chk("t2_accept_state", 32'(dut_state), 32'(ST_CAPTURE));
        run_until_empty(1'b0, 200);
        chk("t2_state_end", 32'(dut_state), 32'(ST_HOLDOFF));

        // Backpressure: ready toggles every cycle
        do_reset();
        toggle_rdy = 1'b1;
        repeat (10) send(1'b0);
        push_record(6);
        send(1'b1);
        run_until_empty(1'b0, 300);
        chk("t3_state_end", 32'(dut_state), 32'(ST_HOLDOFF));
        toggle_rdy    = 1'b0;
        bus.axioready = 1'b1;

        // Trigger held through DRAIN/HOLDOFF; exact re-arm timing; second record
        do_reset();
        repeat (10) send(1'b0);
        push_record(6);
        send(1'b1);
        run_until_empty(1'b1, 200);
        chk("t4_holdoff_h1", 32'(dut_state), 32'(ST_HOLDOFF));
        repeat (4) begin
            send(1'b1);
            chk("t4_holdoff_hold", 32'(dut_state), 32'(ST_HOLDOFF));
        end
        send(1'b1);
        chk("t4_rearm_h6", 32'(dut_state), 32'(ST_ARMED));
        push_record(frame_n);
        for (int i = 0; i < 4; i++) begin
            send(1'b1);
            chk("t4_refill_ignored", 32'(dut_state), 32'(ST_ARMED));
        end
        send(1'b1);
        chk("t4_second_accept", 32'(dut_state), 32'(ST_CAPTURE));
        run_until_empty(1'b0, 200);

        // Pointer wrapped twice: trigger at frame 40 -> frames 36..51
        do_reset();
        repeat (40) send(1'b0);
        push_record(36);
        send(1'b1);
        chk("t5_accept_state", 32'(dut_state), 32'(ST_CAPTURE));
        drain_nobubble("t5");

        // Reset mid-DRAIN, then refill rule applies again
        do_reset();
        repeat (10) send(1'b0);
        push_record(6);
        send(1'b1);
        n_pop = 0;
        begin
            int b = 100;
            while (n_pop < 7 && b > 0) begin
                send(1'b0);
                b--;
            end
        end
        chk("t6_words_before_rst", 32'(n_pop >= 7), 32'd1);
        rst = 1'b1;
        send(1'b0);
        rst = 1'b0;
        sb.delete();
        chk("t6_rst_axiov", 32'(bus.axiov), 32'd0);
        chk("t6_rst_state", 32'(dut_state), 32'(ST_ARMED));
        for (int i = 0; i < 4; i++) begin
            send(1'b1);
            chk("t6_refill_ignored", 32'(dut_state), 32'(ST_ARMED));
        end
        push_record(frame_n - 4);
        send(1'b1);
        chk("t6_accept_state", 32'(dut_state), 32'(ST_CAPTURE));
        run_until_empty(1'b0, 200);
        chk("t6_state_end", 32'(dut_state), 32'(ST_HOLDOFF));

        bus.axiiv = 1'b0;
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
